// File: rtl/uart_tx_arb_pkg.sv
// Shared types and elaboration-time helpers for the uart_tx round-robin scheduler.
// Contents:
//   state_e    - scheduler FSM states (IDLE, GRANT, WAIT), 2-bit encoding
//   clog2      - ceiling log2, used to size counters and indices
//   frame_cyc  - clock cycles reserved per transmitted byte, guard included
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Whole bit periods per frame plus trailing idle guard cycles.
    function automatic int frame_cyc(input int clk_freq, input int uart_bps,
                                     input int frame_bits, input int guard_cyc);
        return (clk_freq / uart_bps) * frame_bits + guard_cyc;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i  [NREQ] - pending request flags
//   ptr_i  [PW]   - index with highest priority this round (must be < NREQ)
//   idx_o  [PW]   - first set request at or above ptr_i, wrapping
//   any_o         - at least one request is set
module uart_tx_arb_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    localparam logic [PW:0] N_W = (PW+1)'(NREQ);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [PW-1:0]     enc_s;
    logic [PW:0]       sum_s;

    // Rotate so ptr_i lands on bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        dbl_s = {req_i, req_i};
        rot_s = NREQ'(dbl_s >> ptr_i);
        enc_s = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                enc_s = PW'(k);
            end else begin
                enc_s = enc_s;
            end
        end
        sum_s = {1'b0, ptr_i} + {1'b0, enc_s};
        if (sum_s >= N_W) begin
            idx_o = PW'(sum_s - N_W);
        end else begin
            idx_o = PW'(sum_s);
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_tx byte transmitter among NREQ producers.
// uart_tx has no busy output, so after issuing a byte this block stays busy for a
// full frame time (FRAME_CYC cycles) before granting again.
// Ports:
//   sys_clk, sys_rst - clock, synchronous active-high reset
//   req_valid [NREQ] - per-requester byte pending; held with data until req_ready
//   req_data  [8*NREQ] - requester i byte on [8i+7:8i]
//   req_ready [NREQ] - one-hot accept strobe during the GRANT cycle
//   po_data   [8]    - byte to uart_tx pi_data (registered, held between transfers)
//   po_flag          - one-cycle strobe to uart_tx pi_flag (registered)
//   busy             - high whenever the scheduler is not IDLE
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FRAME_BITS = 10,
    parameter int GUARD_CYC  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        po_data,
    output logic              po_flag,
    output logic              busy
);

    localparam int FRAME_CYC = frame_cyc(CLK_FREQ, UART_BPS, FRAME_BITS, GUARD_CYC);
    localparam int CW_RAW    = clog2(FRAME_CYC);
    localparam int CW        = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int PW_RAW    = clog2(NREQ);
    localparam int PW        = (PW_RAW < 1) ? 1 : PW_RAW;

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYC - 1);
    localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] gnt_idx_q, gnt_idx_d;
    logic [7:0]    po_data_q, po_data_d;
    logic          po_flag_q, po_flag_d;
    logic          busy_q, busy_d;

    logic [PW-1:0] pick_idx_s;
    logic          pick_any_s;

    uart_tx_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx_s),
        .any_o (pick_any_s)
    );

    // Accept strobe is decoded from the registered grant so it never depends on req_valid.
    always_comb begin
        req_ready = '0;
        if (state_q == GRANT) begin
            req_ready[gnt_idx_q] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        po_data_d = po_data_q;
        po_flag_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    gnt_idx_d = pick_idx_s;
                    state_d   = GRANT;
                end else begin
                    state_d   = IDLE;
                end
            end
            GRANT: begin
                // A requester that dropped valid here forfeits; rr_ptr is left alone
                // so it keeps its priority on the next IDLE evaluation.
                if (req_valid[gnt_idx_q]) begin
                    po_data_d = req_data[{gnt_idx_q, 3'b000} +: 8];
                    po_flag_d = 1'b1;
                    rr_ptr_d  = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + PW'(1);
                    cnt_d     = '0;
                    state_d   = WAIT;
                end else begin
                    state_d   = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            po_data_q <= 8'h00;
            po_flag_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            po_data_q <= po_data_d;
            po_flag_q <= po_flag_d;
            busy_q    <= busy_d;
        end
    end

    assign po_data = po_data_q;
    assign po_flag = po_flag_q;
    assign busy    = busy_q;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin scheduler that shares the single uart_tx byte transmitter between NREQ byte producers, e.g. the sum controller's result stream and a status/echo path.
- uart_tx has no busy output, so this block paces issue. It emits one po_flag pulse per byte, then blocks for a full frame time before it grants again.
- Sits between the producers and uart_tx; its po_data/po_flag drive uart_tx pi_data/pi_flag directly.

Parameters:
- NREQ, 2, number of requesters (2..8).
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- UART_BPS, 9600, baud rate; must match uart_tx.
- FRAME_BITS, 10, bits per frame (start + 8 data + stop).
- GUARD_CYC, 2, extra idle cycles appended after each frame.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte-pending flag. Once asserted, it must hold together with its data until the matching req_ready.
- req_data  in  NREQ*8  requester i byte on bits [8i+7:8i].
- req_ready  out  NREQ  one-hot, one-cycle accept pulse; a transfer occurs when req_valid[i] & req_ready[i].
- po_data  out  8  byte to uart_tx pi_data; registered.
- po_flag  out  1  one-cycle strobe to uart_tx pi_flag; registered.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FRAME_CYC = (CLK_FREQ/UART_BPS)*FRAME_BITS + GUARD_CYC, using integer division. Default 5208*10+2 = 52082.
- Counter width = clog2(FRAME_CYC).
- Reset (synchronous, any state):
  - state=IDLE, cnt=0, rr_ptr=0, gnt_idx=0.
  - po_data=8'h00, po_flag=0, req_ready=0, busy=0.
  - A byte already handed to uart_tx is not tracked; uart_tx shares the same reset.
- IDLE:
  - If any req_valid bit is set: gnt_idx = first set bit searching from rr_ptr upward with wrap; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle):
  - req_ready[gnt_idx]=1, decoded combinationally from state and gnt_idx; all other ready bits are 0.
  - If req_valid[gnt_idx]=1: register po_data=req_data[gnt_idx], set po_flag=1 on the next cycle, rr_ptr=(gnt_idx+1) mod NREQ, cnt=0, go to WAIT.
  - If req_valid[gnt_idx]=0 (protocol violation): no transfer, no po_flag, rr_ptr unchanged, return to IDLE.
- WAIT:
  - po_flag is high only in the first WAIT cycle; po_data holds its value until the next transfer.
  - cnt increments each cycle. When cnt == FRAME_CYC-1: cnt=0, go to IDLE.
- Latency:
  - req_valid first high in IDLE at cycle t -> req_ready at t+1 -> po_flag at t+2.
  - Minimum spacing between po_flag pulses is FRAME_CYC+2 cycles.
- Arbitration:
  - Round-robin, starvation-free: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.
  - A requester asserting valid during GRANT or WAIT is evaluated at the next IDLE.
- Simultaneous requests in IDLE are resolved only by rr_ptr.
- req_valid changing on the IDLE cycle is sampled as seen in that cycle.

Decomposition:
- Package uart_tx_arb_pkg:
  - state enum {IDLE, GRANT, WAIT}, 2-bit encoding.
  - function frame_cyc(CLK_FREQ, UART_BPS, FRAME_BITS, GUARD_CYC).
  - function clog2.
- Sub-module rr_pick: purely combinational.
  - Inputs: req[NREQ], ptr.
  - Outputs: idx, any.
  - Implementation: rotate, priority-encode, unrotate.
- The top holds the FSM, counter and output registers.

Test Plan (bench overrides CLK_FREQ=1000, UART_BPS=100, FRAME_BITS=10, GUARD_CYC=2, so FRAME_CYC=102):
- Single request:
  - Stimulus: req_valid=2'b01, req_data[7:0]=8'hA5 at cycle 10 after reset release.
  - Required: req_ready=2'b01 at cycle 11; po_flag=1 with po_data=8'hA5 at cycle 12 only; busy high from 11 through 113; back in IDLE at 114.
- Both requesters continuously valid:
  - Stimulus: data 8'h11 (req 0) and 8'h22 (req 1); each requester drops valid for 1 cycle after its ready, then reasserts.
  - Required: po_data sequence 11,22,11,22; po_flag spacing exactly 104 cycles.
- Request during WAIT:
  - Stimulus: req 1 asserts valid (data 8'h3C) at WAIT cnt=50.
  - Required: no req_ready until IDLE; then req_ready[1] one cycle after IDLE entry; po_flag at the next cycle.
- Valid withdrawn during GRANT:
  - Stimulus: req 0 drops valid in the GRANT cycle.
  - Required: no po_flag; state returns to IDLE next cycle; rr_ptr stays 0; a later request from req 0 is granted first.
- Reset mid-frame:
  - Stimulus: sys_rst=1 for 1 cycle at WAIT cnt=40.
  - Required: next cycle po_flag=0, busy=0, req_ready=0, po_data=8'h00; a pending request is granted 1 cycle after reset deasserts and is followed by a full 102-cycle WAIT.
- Wrap of rr_ptr with NREQ=3:
  - Stimulus: all three requesters valid.
  - Required: grant order 0,1,2,0; rr_ptr returns to 0 after the grant to 2.
